// File: rtl/seq_alu.sv
// seq_alu: registered 8-opcode ALU with a multi-cycle shift-add multiply and start/busy/done handshake
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y,
  output logic               err
);
  localparam int YW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [YW-1:0] mcand, acc, acc_n, alu_y;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, diff;
  logic accept, last;
  assign accept = start && state == IDLE;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == MUL;
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  assign sum = {1'b0, a} + {1'b0, b};
  // the extra top bit of the widened difference is the borrow
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    alu_y = '0;
    alu_y = op == 3'd0 ? YW'(sum) :
            op == 3'd1 ? YW'(diff) :
            op == 3'd3 ? YW'(a & b) :
            op == 3'd4 ? YW'(a | b) :
            op == 3'd5 ? YW'(a ^ b) :
            op == 3'd6 ? YW'(a) : '0;
  end
  always_comb begin
    state_n = state;
    if (accept && op == 3'd2) state_n = MUL;
    else if (busy && last) state_n = IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      y      <= '0;
      err    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= (accept && op != 3'd2) || (busy && last);
      if (accept && op == 3'd2) begin
        mcand  <= YW'(a);
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (accept) begin
        y   <= alu_y;
        err <= op == 3'd7;
      end else if (busy) begin
        acc    <= acc_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          y   <= acc_n;
          err <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized scoreboard bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
  localparam int W = 8;
  logic clock = 0, reset = 1, start = 0;
  logic [2:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic busy, done, err;
  logic [2*W-1:0] y;
  int checks = 0, errors = 0;
  logic [2*W:0] exp_q[$];

  always #5 clock = ~clock;

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W:0] model(input int o, input int x, input int z);
    int r;
    bit e;
    int m;
    m = (1 << W) - 1;
    e = 0;
    case (o)
      0: r = x + z;
      1: r = ((x - z) & m) + (x < z ? (1 << W) : 0);
      2: r = x * z;
      3: r = x & z;
      4: r = x | z;
      5: r = x ^ z;
      6: r = x;
      default: begin r = 0; e = 1; end
    endcase
    return {e, r[2*W-1:0]};
  endfunction

  always @(negedge clock) begin : mon
    logic [2*W:0] e;
    if (!reset && done) begin
      chk("busy_with_done", busy, 0);
      if (exp_q.size() == 0) chk("unexpected_done", done, 0);
      else begin
        e = exp_q.pop_front();
        chk("y", y, e[2*W-1:0]);
        chk("err", err, e[2*W]);
      end
    end
  end

  task automatic issue(input int o, input int x, input int z, input bit push = 1);
    start = 1;
    op = 3'(o);
    a = W'(x);
    b = W'(z);
    if (push) exp_q.push_back(model(o, x, z));
    @(posedge clock);
    #1;
    start = 0;
    op = 3'($urandom);
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done(input int lat, input string name);
    int n, nb;
    bit got;
    n = 0;
    nb = 0;
    got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clock);
      if (busy) nb++;
      if (done) begin got = 1; n = i; end
    end
    chk({name, "_latency"}, n, lat);
    chk({name, "_busy_cycles"}, nb, lat - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_err", err, 0);
    @(negedge clock) reset = 0;
    @(negedge clock) issue(0, 200, 100);
    wait_done(1, "add");
    @(negedge clock) chk("done_drop", done, 0);
    issue(1, 5, 7);
    wait_done(1, "sub_borrow");
    @(negedge clock) issue(1, 7, 5);
    wait_done(1, "sub");
    @(negedge clock) issue(2, 255, 255);
    @(negedge clock);
    start = 1; op = 0; a = 1; b = 1;
    @(posedge clock);
    #1 start = 0;
    wait_done(W, "mul_ignored_start");
    @(negedge clock) issue(2, 0, 255);
    wait_done(W + 1, "mul_zero");
    @(negedge clock) issue(7, 3, 4);
    wait_done(1, "invalid");
    @(negedge clock) issue(4, 'hF0, 'h0F);
    wait_done(1, "or");
    @(negedge clock) issue(2, 37, 201);
    wait_done(W + 1, "mul");
    issue(6, 'h3C, 0);
    wait_done(1, "start_on_done");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (k > 0) chk("b2b_done", done, 1);
      start = 1;
      op = k == 0 ? 3'd3 : k == 1 ? 3'd5 : 3'd0;
      a = W'($urandom);
      b = W'($urandom);
      exp_q.push_back(model(int'(op), int'(a), int'(b)));
    end
    @(posedge clock);
    #1 start = 0;
    @(negedge clock) chk("b2b_done_last", done, 1);
    @(negedge clock) chk("b2b_done_drop", done, 0);
    issue(2, 13, 11, 0);
    repeat (3) @(posedge clock);
    #3 reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_y", y, 0);
    chk("abort_err", err, 0);
    @(negedge clock) reset = 0;
    @(negedge clock) issue(6, 'hA5, 0);
    wait_done(1, "pass_after_reset");
    for (int i = 0; i < 60; i++) begin
      int o;
      o = $urandom_range(0, 7);
      @(negedge clock) issue(o, $urandom_range(0, 255), $urandom_range(0, 255));
      wait_done(o == 2 ? W + 1 : 1, "rand");
    end
    repeat (3) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
